// File: rtl/ysyx_22050854_fetch_ctrl.sv
// ysyx_22050854_fetch_ctrl: fetch sequencer with one outstanding I-cache request,
// a one-entry instruction buffer toward IF/ID and redirect-driven wrong-path kill.
module ysyx_22050854_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        redir_trap_vld,
   input  logic [31:0] redir_trap_pc,
   input  logic        redir_br_vld,
   input  logic [31:0] redir_br_pc,
   output logic        ic_req_valid,
   output logic [31:0] ic_req_addr,
   input  logic        ic_req_ready,
   input  logic        ic_resp_valid,
   input  logic [31:0] ic_resp_inst,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   input  logic        id_ready
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
   state_t      state, state_n;
   logic [31:0] fetch_pc, fetch_pc_n, req_pc, req_pc_n, if_pc_n, if_inst_n, tgt;
   logic        kill, kill_n, if_valid_n, redir, hs, resp, take;
   always_comb begin
      redir        = redir_trap_vld | redir_br_vld;
      tgt          = redir_trap_vld ? redir_trap_pc : redir_br_pc;
      ic_req_valid = state == S_REQ && !(if_valid && !id_ready);
      ic_req_addr  = fetch_pc;
      hs           = ic_req_valid & ic_req_ready;
      resp         = state == S_WAIT && ic_resp_valid;
      take         = resp & ~kill & ~redir;
      state_n      = state == S_IDLE ? S_REQ : hs ? S_WAIT : resp ? S_REQ : state;
      req_pc_n     = hs ? fetch_pc : req_pc;
      // a request accepted alongside a redirect is already wrong-path
      kill_n       = hs ? redir : resp ? 1'b0 : (state == S_WAIT && redir) ? 1'b1 : kill;
      fetch_pc_n   = redir ? tgt : take ? req_pc + 32'd4 : fetch_pc;
      if_valid_n   = redir ? 1'b0 : take ? 1'b1 : (if_valid && id_ready) ? 1'b0 : if_valid;
      if_pc_n      = take ? req_pc : if_pc;
      if_inst_n    = take ? ic_resp_inst : if_inst;
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
         kill     <= 1'b0;
         if_valid <= 1'b0;
         if_pc    <= 32'd0;
         if_inst  <= 32'd0;
      end else begin
         state    <= state_n;
         fetch_pc <= fetch_pc_n;
         req_pc   <= req_pc_n;
         kill     <= kill_n;
         if_valid <= if_valid_n;
         if_pc    <= if_pc_n;
         if_inst  <= if_inst_n;
      end
   end
endmodule

// File: tb/tb_ysyx_22050854_fetch_ctrl.sv
// tb_ysyx_22050854_fetch_ctrl: directed stimulus with a scoreboard of expected
// I-cache request addresses and delivered (pc, inst) pairs; I-cache returns addr ^ 12345678.
module tb_ysyx_22050854_fetch_ctrl;
   logic        clock, reset;
   logic        redir_trap_vld, redir_br_vld;
   logic [31:0] redir_trap_pc, redir_br_pc;
   logic        ic_req_valid, ic_req_ready, ic_resp_valid;
   logic [31:0] ic_req_addr, ic_resp_inst;
   logic        if_valid, id_ready;
   logic [31:0] if_pc, if_inst;
   logic [31:0] req_q[$];
   logic [63:0] inst_q[$];
   int          checks = 0, errors = 0, lat = 1;

   ysyx_22050854_fetch_ctrl dut (
      .clock(clock), .reset(reset),
      .redir_trap_vld(redir_trap_vld), .redir_trap_pc(redir_trap_pc),
      .redir_br_vld(redir_br_vld), .redir_br_pc(redir_br_pc),
      .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
      .ic_resp_valid(ic_resp_valid), .ic_resp_inst(ic_resp_inst),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .id_ready(id_ready)
   );

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // I-cache model: one response per accepted request, lat cycles after acceptance
   initial begin
      logic        hs;
      logic [31:0] a, pa;
      int          cnt;
      cnt = 0; pa = 0;
      ic_resp_valid = 0; ic_resp_inst = 0;
      forever begin
         @(negedge clock);
         hs = ic_req_valid && ic_req_ready && reset;
         a  = ic_req_addr;
         @(posedge clock);
         #1;
         if (!reset) cnt = 0;
         if (hs) begin cnt = lat; pa = a; end
         ic_resp_valid = cnt == 1;
         ic_resp_inst  = cnt == 1 ? pa ^ 32'h1234_5678 : 32'd0;
         if (cnt > 0) cnt--;
      end
   end

   // monitor: compare every handshake and every consumed instruction against the queues
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clock);
         if (reset && ic_req_valid && ic_req_ready) begin
            if (req_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL req_extra: got addr %h expected no request", ic_req_addr);
            end else chk("req_addr", ic_req_addr, req_q.pop_front());
         end
         if (reset && if_valid && id_ready && !(redir_trap_vld || redir_br_vld)) begin
            if (inst_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL inst_extra: got pc %h inst %h expected none", if_pc, if_inst);
            end else begin
               e = inst_q.pop_front();
               chk("if_pc", if_pc, e[63:32]);
               chk("if_inst", if_inst, e[31:0]);
            end
         end
      end
   end

   initial begin
      reset = 0; id_ready = 1; ic_req_ready = 1;
      redir_trap_vld = 0; redir_trap_pc = 0; redir_br_vld = 0; redir_br_pc = 0;
      req_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0100,
                32'h8000_0104, 32'h8000_0200, 32'h8000_0204, 32'hFFFF_FFFC, 32'h0000_0000};
      inst_q = '{{32'h8000_0000, 32'h9234_5678}, {32'h8000_0004, 32'h9234_567C},
                 {32'h8000_0008, 32'h9234_5670}, {32'h8000_0100, 32'h9234_5778},
                 {32'h8000_0200, 32'h9234_5478}, {32'hFFFF_FFFC, 32'hEDCB_A984},
                 {32'h0000_0000, 32'h1234_5678}};
      step(3);
      chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
      chk("rst_req_addr", ic_req_addr, 32'h8000_0000);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, 32'd0);
      reset = 1;
      @(negedge clock);
      chk("idle_req_valid", {31'd0, ic_req_valid}, 32'd0);
      step(1);
      @(negedge clock);
      chk("first_req_valid", {31'd0, ic_req_valid}, 32'd1);
      chk("first_req_addr", ic_req_addr, 32'h8000_0000);
      step(3);
      id_ready = 0;
      step(1);
      repeat (3) begin
         @(negedge clock);
         chk("bp_req_valid", {31'd0, ic_req_valid}, 32'd0);
         chk("bp_if_valid", {31'd0, if_valid}, 32'd1);
         chk("bp_if_pc", if_pc, 32'h8000_0004);
         chk("bp_if_inst", if_inst, 32'h9234_567C);
         step(1);
      end
      id_ready = 1;
      step(2);
      lat = 2;
      step(1);
      redir_br_vld = 1; redir_br_pc = 32'h8000_0100;
      step(1);
      redir_br_vld = 0; lat = 1;
      @(negedge clock);
      chk("kill_if_valid_a", {31'd0, if_valid}, 32'd0);
      step(1);
      @(negedge clock);
      chk("kill_if_valid_b", {31'd0, if_valid}, 32'd0);
      step(3);
      redir_trap_vld = 1; redir_trap_pc = 32'h8000_0200;
      redir_br_vld = 1; redir_br_pc = 32'h8000_0100;
      step(1);
      redir_trap_vld = 0; redir_br_vld = 0;
      step(3);
      redir_br_vld = 1; redir_br_pc = 32'hFFFF_FFFC;
      step(1);
      redir_br_vld = 0;
      step(4);
      ic_req_ready = 0;
      step(4);
      chk("req_left", req_q.size(), 32'd0);
      chk("inst_left", inst_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
